// File: rtl/trace_pkg.sv
// Shared types and helpers for the writeback-trace UART serialiser.
// Latency: none (declarations only).
// Backpressure: not applicable.
package trace_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         REC_BYTES = 10;
    localparam int         REC_W     = 72;

    typedef logic [4:0]       reg_idx_t;
    typedef logic [REC_W-1:0] rec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Record layout: {pc[31:0], 3'b000, reg[4:0], value[31:0]}
    function automatic rec_t make_rec(logic [31:0] pc, reg_idx_t rg, logic [31:0] value);
        return {pc, 3'b000, rg, value};
    endfunction

    // Packet byte 0 is the sync marker; bytes 1..9 walk the record MSB first.
    function automatic logic [7:0] byte_sel(rec_t rec, logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = SYNC_BYTE;
            4'd1:    b = rec[71:64];
            4'd2:    b = rec[63:56];
            4'd3:    b = rec[55:48];
            4'd4:    b = rec[47:40];
            4'd5:    b = rec[39:32];
            4'd6:    b = rec[31:24];
            4'd7:    b = rec[23:16];
            4'd8:    b = rec[15:8];
            4'd9:    b = rec[7:0];
            default: b = SYNC_BYTE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/trace_uart_tx_if.sv
// Writeback trace bus from the CPU retire stage into the trace serialiser.
// Latency: none (wires only).
// Backpressure: none; the source never stalls, the sink drops on overflow.
interface trace_uart_tx_if;

    logic                wb_have_inst;
    logic [31:0]         wb_pc;
    logic                wb_ena;
    trace_pkg::reg_idx_t wb_reg;
    logic [31:0]         wb_value;

    modport master (
        output wb_have_inst, wb_pc, wb_ena, wb_reg, wb_value
    );

    modport slave (
        input wb_have_inst, wb_pc, wb_ena, wb_reg, wb_value
    );

endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with show-ahead read data.
// Latency: a push is visible on dout/empty one cycle after the push edge.
// Backpressure: push while full is ignored unless a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB separates the full case from the empty case.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/trace_uart_tx.sv
// Captures retired register writes and streams each as a 10-byte 8N1 UART packet.
// Latency: start bit begins one cycle after the capture edge when idle; packet is 100*BAUD_DIV cycles.
// Backpressure: none upstream; records arriving with the FIFO full and no pop are dropped and flagged.
module trace_uart_tx
    import trace_pkg::*;
#(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    trace_uart_tx_if.slave   wb,
    output logic             uart_tx,
    output logic             busy,
    output logic             fifo_full,
    output logic             overflow
);

    localparam int              CNT_W     = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]      LAST_BYTE = 4'(REC_BYTES - 1);

    tx_state_t        state, state_n;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [3:0]       byte_idx, byte_idx_n;
    rec_t             rec, rec_n;
    logic             tx_n;
    logic [7:0]       cur_byte;
    logic             baud_end;

    logic             qualify;
    logic             pop;
    logic             fifo_empty;
    rec_t             fifo_dout;

    assign qualify  = wb.wb_have_inst && wb.wb_ena && (wb.wb_reg != '0);
    assign baud_end = (baud_cnt == BAUD_LAST);
    assign busy     = (state != IDLE) || !fifo_empty;

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (qualify),
        .pop   (pop),
        .din   (make_rec(wb.wb_pc, wb.wb_reg, wb.wb_value)),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Next-state logic: bit timing, byte sequencing, record fetch and the next line level.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        rec_n      = rec;
        pop        = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    rec_n      = fifo_dout;
                    byte_idx_n = '0;
                    baud_cnt_n = '0;
                    state_n    = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    state_n    = DATA;
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_cnt_n = '0;
                    if (byte_idx != LAST_BYTE) begin
                        byte_idx_n = byte_idx + 1'b1;
                        state_n    = START;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next packet with no idle bit.
                        pop        = 1'b1;
                        rec_n      = fifo_dout;
                        byte_idx_n = '0;
                        state_n    = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level is derived from the next state so uart_tx is a plain register.
        cur_byte = byte_sel(rec_n, byte_idx_n);
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = cur_byte[bit_idx_n];
            default: tx_n = 1'b1;
        endcase
    end

    // FSM, counters, record register and the registered serial line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            rec      <= '0;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            byte_idx <= byte_idx_n;
            rec      <= rec_n;
            uart_tx  <= tx_n;
        end
    end

    // Sticky drop flag: a qualifying record met a full FIFO with no pop to make room.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (qualify && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

endmodule
